// File: rtl/addsub_nibble_seq.sv
// Nibble-serial W-bit add/subtract sequencer driving an external 4-bit adder.
// Optional zero/overflow flags: define ADDSUB_FLAGS_EN.
module addsub_nibble_seq #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4*NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  output logic [3:0]   adder_a,
  output logic [3:0]   adder_b,
  output logic         adder_c0,
  input  logic [3:0]   adder_s,
  input  logic         adder_c4,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic         out_c
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic         out_z,
  output logic         out_v
`endif
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, b_q, r_q, r_nxt;
  logic [IW-1:0] idx_q;
  logic [IW+1:0] base;
  logic          cr_q;
  logic          last;

  assign base  = {idx_q, 2'b00};
  assign last  = (idx_q == IW'(NIBBLES-1));
  assign out_r = r_q;
  assign out_c = cr_q;

  // Result as it will look once the current nibble lands
  always_comb begin
    r_nxt = r_q;
    r_nxt[base +: 4] = adder_s;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    adder_a   = 4'h0;
    adder_b   = 4'h0;
    adder_c0  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        adder_a  = a_q[base +: 4];
        adder_b  = b_q[base +: 4];
        adder_c0 = cr_q;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      idx_q   <= '0;
      cr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        a_q   <= in_a;
        b_q   <= in_b ^ {W{in_sub}};
        cr_q  <= in_sub;
        idx_q <= '0;
      end else if (state_q == RUN) begin
        r_q   <= r_nxt;
        cr_q  <= adder_c4;
        idx_q <= last ? '0 : idx_q + 1'b1;
      end
    end
  end

`ifdef ADDSUB_FLAGS_EN
  logic z_q, v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b0;
      v_q <= 1'b0;
    end else if (state_q == RUN && last) begin
      z_q <= (r_nxt == '0);
      v_q <= (a_q[W-1] == b_q[W-1]) & (adder_s[3] != a_q[W-1]);
    end
  end

  assign out_z = z_q;
  assign out_v = v_q;
`endif

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Directed scoreboard bench for addsub_nibble_seq (NIBBLES=4).
// Flag checks are active when ADDSUB_FLAGS_EN is defined.
module tb_addsub_nibble_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic        in_sub;
  logic [3:0]  adder_a, adder_b, adder_s;
  logic        adder_c0, adder_c4;
  logic        out_valid, out_ready;
  logic [15:0] out_r;
  logic        out_c;
  logic        out_z, out_v;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        z;
    logic        v;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Behavioural stand-in for the external 4-bit adder
  assign {adder_c4, adder_s} = {1'b0, adder_a} + {1'b0, adder_b} + {4'b0, adder_c0};

`ifndef ADDSUB_FLAGS_EN
  assign out_z = 1'b0;
  assign out_v = 1'b0;
`endif

  addsub_nibble_seq #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_c0  (adder_c0),
    .adder_s   (adder_s),
    .adder_c4  (adder_c4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_c     (out_c)
`ifdef ADDSUB_FLAGS_EN
    ,
    .out_z     (out_z),
    .out_v     (out_v)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input exp_t e);
`ifdef ADDSUB_FLAGS_EN
    chk({tag, "_z"}, 32'(out_z), 32'(e.z));
    chk({tag, "_v"}, 32'(out_v), 32'(e.v));
`endif
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_r"}, 32'(out_r), 32'd0);
    chk({tag, "_out_c"}, 32'(out_c), 32'd0);
    chk({tag, "_adder"}, {23'd0, adder_a, adder_b, adder_c0}, 32'd0);
`ifdef ADDSUB_FLAGS_EN
    chk({tag, "_zv"}, {30'd0, out_z, out_v}, 32'd0);
`endif
  endtask

  task automatic run_op(
    input string       tag,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        s,
    input logic [15:0] er,
    input logic        ec,
    input logic        ez,
    input logic        ev,
    input int          bp
  );
    exp_t e;
    int   n;
    @(negedge clk);
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    in_a     = a;
    in_b     = b;
    in_sub   = s;
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{r: er, c: ec, z: ez, v: ev});
    #1;
    in_valid = 1'b0;
    in_a     = 16'h0;
    in_b     = 16'h0;
    in_sub   = 1'b0;
    chk({tag, "_run0_a"}, 32'(adder_a), 32'(a & 16'h000f));
    chk({tag, "_run0_b"}, 32'(adder_b), 32'((b & 16'h000f) ^ {12'h0, {4{s}}}));
    chk({tag, "_run0_c0"}, 32'(adder_c0), 32'(s));
    chk({tag, "_run_ready"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
    if (!out_valid) begin
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k < bp; k++) begin
      in_valid = 1'b1;
      in_a     = 16'h5a5a;
      in_b     = 16'h1234;
      in_sub   = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_bp_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_bp_r"}, 32'(out_r), 32'(e.r));
      chk_flags({tag, "_bp"}, e);
    end
    in_valid = 1'b0;
    chk({tag, "_r"}, 32'(out_r), 32'(e.r));
    chk({tag, "_c"}, 32'(out_c), 32'(e.c));
    chk_flags(tag, e);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    #1;
    chk_reset_outs("reset_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outs("reset_release");

    run_op("sub_nob",  16'h000d, 16'h0005, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b0, 0);
    run_op("sub_bor",  16'h0005, 16'h000d, 1'b1, 16'hfff8, 1'b0, 1'b0, 1'b0, 0);
    run_op("add_wrap", 16'hffff, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 0);
    run_op("add_ovf",  16'h7fff, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 0);
    run_op("bp",       16'h8000, 16'h0001, 1'b1, 16'h7fff, 1'b1, 1'b0, 1'b1, 5);

    // Abort an operation two RUN cycles in
    @(negedge clk);
    in_a     = 16'habcd;
    in_b     = 16'h1357;
    in_sub   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("reset_midrun");
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) highs++;
    end
    chk("abort_no_valid", 32'(highs), 32'd0);

    run_op("post_reset", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_nibble_seq.md
# addsub_nibble_seq

Nibble-serial multi-precision add/subtract sequencer that wraps the team's 4-bit `adder` (ports A, B, c0 → S, c4). It accepts W-bit operand pairs over a valid/ready handshake and applies the B-invert and carry-in subtract scheme. It drives the adder one nibble per cycle, chaining c4 into the next c0, and assembles the result. The adder is instantiated outside this block and is fed through dedicated ports, so this block sits directly upstream of the adder and directly downstream of it.

## Interface
Parameters:
- `NIBBLES`, default 4: operand width in nibbles; W = 4*NIBBLES. Legal range 1..16.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand request valid.
- `in_ready` output 1: block can accept a request.
- `in_a` input W: operand A.
- `in_b` input W: operand B.
- `in_sub` input 1: 1 = A−B, 0 = A+B.
- `adder_a` output 4: to adder A.
- `adder_b` output 4: to adder B, already XORed with {4{sub}}.
- `adder_c0` output 1: to adder c0.
- `adder_s` input 4: from adder S (combinational return).
- `adder_c4` input 1: from adder c4.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `out_r` output W: result.
- `out_c` output 1: final carry. For subtract, 1 means no borrow.
- `out_z` output 1: result == 0. Present only under `ADDSUB_FLAGS_EN`.
- `out_v` output 1: signed overflow. Present only under `ADDSUB_FLAGS_EN`.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE: `in_ready`=1. When `in_valid`&`in_ready` at a rising edge, the block:
  - registers A, B^{W{sub}}, and sub;
  - sets nibble index i=0 and carry register cr=sub;
  - goes to RUN.
- RUN: drives `adder_a`=A[4i+3:4i], `adder_b`=B'[4i+3:4i], `adder_c0`=cr. At each edge it does:
  - R[4i+3:4i] ← `adder_s`;
  - cr ← `adder_c4`;
  - i ← i+1.
  - After nibble NIBBLES−1 it goes to DONE.
- DONE: `out_valid`=1. `out_r`, `out_c` (=cr), and flags are held stable until `out_valid`&`out_ready`, then the block returns to IDLE.
- `in_ready`=0 in RUN and DONE. There is no queuing and no bypass. `in_*` values are ignored outside IDLE.
- Adder ports are driven to 0 in IDLE and DONE.
- Arithmetic: out_r = (A + (sub ? ~B+1 : B)) mod 2^W. out_c = carry out of bit W−1.
- The result register is undefined-free: it is cleared on reset and overwritten nibble by nibble.

## Timing
- Reset (async assert, sync-free deassert): state=IDLE, `in_ready`=1, `out_valid`=0, `out_r`=0, `out_c`=0, `out_z`=0, `out_v`=0, adder ports 0, i=0, cr=0.
- Reset asserted in RUN or DONE aborts the operation immediately. The pending result is discarded and no `out_valid` is produced.
- Latency: request accepted at edge k → `out_valid` high after edge k+NIBBLES.
- With `out_ready` held high, the result is consumed at edge k+NIBBLES+1. The earliest next accept is edge k+NIBBLES+2.
- `out_valid` never drops without a handshake. `out_r`/flags are constant while `out_valid`=1 and `out_ready`=0.
- The adder path is combinational within a RUN cycle: register → adder → register. No multicycle constraint applies.
- NIBBLES=1: a single RUN cycle, with behaviour identical to a direct adder call plus registering.

## Configuration
- `ADDSUB_FLAGS_EN` defined:
  - `out_z` = (R==0), registered at entry to DONE.
  - `out_v` = (A[W−1]==B'[W−1]) & (R[W−1]!=A[W−1]), registered at entry to DONE.
- `ADDSUB_FLAGS_EN` undefined: the `out_z`/`out_v` ports and their logic are absent. All other behaviour and timing are unchanged.

## Test plan
(NIBBLES=4, `ADDSUB_FLAGS_EN` defined unless stated.)
- Subtract, no borrow: A=0x000D, B=0x0005, sub=1 → out_r=0x0008, out_c=1, out_z=0, out_v=0, out_valid 4 cycles after accept. The first RUN cycle shows adder_b=0xA and adder_c0=1.
- Subtract with borrow: A=0x0005, B=0x000D, sub=1 → out_r=0xFFF8, out_c=0, out_v=0.
- Add with wrap-around: A=0xFFFF, B=0x0001, sub=0 → out_r=0x0000, out_c=1, out_z=1, out_v=0.
- Signed overflow: A=0x7FFF, B=0x0001, sub=0 → out_r=0x8000, out_c=0, out_v=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_r and flags stable, in_ready=0, and a new in_valid is ignored. Raising out_ready gives a one-cycle handshake, then in_ready=1.
- Reset mid-RUN: deassert rst_n after 2 RUN cycles → all outputs at reset values immediately, no out_valid. A subsequent request A=0x1234, B=0x1111, sub=0 → 0x2345, out_c=0. Repeat this request with the macro undefined: out_r and out_c are identical.
